// File: rtl/number_pkg.sv
// ============================================================================
// Module   : number_pkg
// Brief    : Shared types and constants for the sequence number checker.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package number_pkg;

    localparam int NUM_W                  = 16;
    localparam int RUN_W                  = 4;
    localparam int DEF_LOCK_THRESHOLD     = 4;
    localparam int DEF_LOSS_THRESHOLD     = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    // Successor of a sample; wraps 0xFFFF -> 0x0000.
    function automatic logic [NUM_W-1:0] next_expected(input logic [NUM_W-1:0] v);
        return v + {{(NUM_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

`default_nettype wire

// File: rtl/number_checker_sat_counter.sv
// ============================================================================
// Module   : sat_counter
// Brief    : Saturating up-counter with synchronous clear (clear wins).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic             w_at_max;

    assign w_at_max = &count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (inc_i && !w_at_max) begin
            count_q <= count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/number_checker.sv
// ============================================================================
// Module   : number_checker
// Brief    : Locks onto an incrementing 16-bit sample stream and counts errors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module number_checker
    import number_pkg::*;
#(
    parameter int LOCK_THRESHOLD = DEF_LOCK_THRESHOLD,
    parameter int LOSS_THRESHOLD = DEF_LOSS_THRESHOLD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             num_valid,
    input  logic [NUM_W-1:0] num_data,
    output logic             num_ready,
    input  logic             clear_counts,
    output logic             locked,
    output logic             mismatch,
    output logic             lock_lost,
    output logic [NUM_W-1:0] error_count,
    output logic [NUM_W-1:0] match_count
);

    localparam logic [RUN_W-1:0] C_LOCK_RUN = RUN_W'(LOCK_THRESHOLD);
    localparam logic [RUN_W-1:0] C_LOSS_RUN = RUN_W'(LOSS_THRESHOLD);
    localparam logic [RUN_W-1:0] C_RUN_ONE  = RUN_W'(1);

    state_t           state_q, state_d;
    logic [NUM_W-1:0] expected_q, expected_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [RUN_W-1:0] miss_q, miss_d;
    logic             locked_q;
    logic             mismatch_q, mismatch_d;
    logic             lock_lost_q, lock_lost_d;

    logic             w_accept;
    logic             w_in_seq;
    logic [NUM_W-1:0] w_next_exp;
    logic [RUN_W-1:0] w_run_inc;
    logic [RUN_W-1:0] w_miss_inc;
    logic             w_err_inc;
    logic             w_match_inc;

    assign num_ready  = !reset && !clear_counts;
    assign w_accept   = num_valid && num_ready;
    assign w_in_seq   = (num_data == expected_q);
    assign w_next_exp = next_expected(num_data);
    assign w_run_inc  = run_q + C_RUN_ONE;
    assign w_miss_inc = miss_q + C_RUN_ONE;

    always_comb begin
        state_d     = state_q;
        expected_d  = expected_q;
        run_d       = run_q;
        miss_d      = miss_q;
        mismatch_d  = 1'b0;
        lock_lost_d = 1'b0;
        w_err_inc   = 1'b0;
        w_match_inc = 1'b0;

        if (w_accept) begin
            // Every accepted sample re-anchors the expected value, hit or miss.
            expected_d = w_next_exp;
            case (state_q)
                IDLE: begin
                    run_d   = C_RUN_ONE;
                    state_d = ACQUIRE;
                end
                ACQUIRE: begin
                    if (w_in_seq) begin
                        run_d = w_run_inc;
                        if (w_run_inc == C_LOCK_RUN) begin
                            state_d = LOCKED;
                            miss_d  = '0;
                        end
                    end else begin
                        run_d = C_RUN_ONE;
                    end
                end
                LOCKED: begin
                    if (w_in_seq) begin
                        w_match_inc = 1'b1;
                        miss_d      = '0;
                    end else begin
                        mismatch_d = 1'b1;
                        w_err_inc  = 1'b1;
                        miss_d     = w_miss_inc;
                        if (w_miss_inc == C_LOSS_RUN) begin
                            lock_lost_d = 1'b1;
                            state_d     = ACQUIRE;
                            run_d       = C_RUN_ONE;
                            miss_d      = '0;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            expected_q  <= '0;
            run_q       <= '0;
            miss_q      <= '0;
            locked_q    <= 1'b0;
            mismatch_q  <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            expected_q  <= expected_d;
            run_q       <= run_d;
            miss_q      <= miss_d;
            locked_q    <= (state_d == LOCKED);
            mismatch_q  <= mismatch_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    sat_counter #(
        .WIDTH   (NUM_W)
    ) u_error_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (w_err_inc),
        .clr_i   (clear_counts),
        .count_o (error_count)
    );

    sat_counter #(
        .WIDTH   (NUM_W)
    ) u_match_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (w_match_inc),
        .clr_i   (clear_counts),
        .count_o (match_count)
    );

    assign locked    = locked_q;
    assign mismatch  = mismatch_q;
    assign lock_lost = lock_lost_q;

endmodule

`default_nettype wire

// File: tb/tb_number_checker.sv
// ============================================================================
// Module   : tb_number_checker
// Brief    : Scoreboard bench for number_checker with directed sample vectors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_number_checker;

    typedef struct packed {
        logic        l;
        logic        m;
        logic        ll;
        logic [15:0] e;
        logic [15:0] c;
    } resp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        num_valid = 1'b0;
    logic [15:0] num_data = 16'h0000;
    logic        clear_counts = 1'b0;
    logic        num_ready;
    logic        locked;
    logic        mismatch;
    logic        lock_lost;
    logic [15:0] error_count;
    logic [15:0] match_count;

    int    n_checks = 0;
    int    n_fail   = 0;
    resp_t exp_q[$];
    logic  mon_acc;

    number_checker #(
        .LOCK_THRESHOLD (4),
        .LOSS_THRESHOLD (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .num_valid    (num_valid),
        .num_data     (num_data),
        .num_ready    (num_ready),
        .clear_counts (clear_counts),
        .locked       (locked),
        .mismatch     (mismatch),
        .lock_lost    (lock_lost),
        .error_count  (error_count),
        .match_count  (match_count)
    );

    always #5 clk = ~clk;

    function automatic resp_t cur_resp();
        return '{l: locked, m: mismatch, ll: lock_lost, e: error_count, c: match_count};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepting edge must have a queued expectation.
    always @(posedge clk) begin
        mon_acc = num_valid && num_ready;
        #1;
        if (mon_acc) begin
            if (exp_q.size() == 0) begin
                check("unexpected_accept", 64'd1, 64'd0);
            end else begin
                check("sample_response", 64'(cur_resp()), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic apply(input logic [15:0] d, input logic l, input logic m,
                         input logic ll, input logic [15:0] e, input logic [15:0] c);
        num_valid = 1'b1;
        num_data  = d;
        exp_q.push_back('{l: l, m: m, ll: ll, e: e, c: c});
    endtask

    task automatic send(input logic [15:0] d, input logic l, input logic m,
                        input logic ll, input logic [15:0] e, input logic [15:0] c);
        @(negedge clk);
        apply(d, l, m, ll, e, c);
    endtask

    task automatic idle();
        @(negedge clk);
        num_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        num_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("reset_outputs", 64'(cur_resp()), 64'd0);
        check("reset_ready", 64'(num_ready), 64'd0);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Lock after four consecutive samples
        do_reset();
        send(16'h1234, 0, 0, 0, 0, 0);
        send(16'h1235, 0, 0, 0, 0, 0);
        send(16'h1236, 0, 0, 0, 0, 0);
        send(16'h1237, 1, 0, 0, 0, 0);

        // Wrap-around is in sequence
        do_reset();
        send(16'hFFFB, 0, 0, 0, 0, 0);
        send(16'hFFFC, 0, 0, 0, 0, 0);
        send(16'hFFFD, 0, 0, 0, 0, 0);
        send(16'hFFFE, 1, 0, 0, 0, 0);
        send(16'hFFFF, 1, 0, 0, 0, 1);
        send(16'h0000, 1, 0, 0, 0, 2);

        // Single mismatch, resync, miss run cleared by a hit
        do_reset();
        send(16'h00FC, 0, 0, 0, 0, 0);
        send(16'h00FD, 0, 0, 0, 0, 0);
        send(16'h00FE, 0, 0, 0, 0, 0);
        send(16'h00FF, 1, 0, 0, 0, 0);
        send(16'h0100, 1, 0, 0, 0, 1);
        send(16'h0050, 1, 1, 0, 1, 1);
        send(16'h0051, 1, 0, 0, 1, 2);
        send(16'h0200, 1, 1, 0, 2, 2);
        send(16'h0300, 1, 1, 0, 3, 2);
        send(16'h0301, 1, 0, 0, 3, 3);
        send(16'h0400, 1, 1, 0, 4, 3);

        // Three misses lose lock; offending sample seeds the new run
        do_reset();
        send(16'h0010, 0, 0, 0, 0, 0);
        send(16'h0011, 0, 0, 0, 0, 0);
        send(16'h0012, 0, 0, 0, 0, 0);
        send(16'h0013, 1, 0, 0, 0, 0);
        send(16'h0AAA, 1, 1, 0, 1, 0);
        send(16'h0555, 1, 1, 0, 2, 0);
        send(16'h0F0F, 0, 1, 1, 3, 0);
        send(16'h0F10, 0, 0, 0, 3, 0);
        send(16'h0F11, 0, 0, 0, 3, 0);
        send(16'h0F12, 1, 0, 0, 3, 0);

        // Generator stream with initial resync, then clear_counts
        do_reset();
        send(16'h4A46, 0, 0, 0, 0, 0);
        send(16'h0000, 0, 0, 0, 0, 0);
        send(16'h0001, 0, 0, 0, 0, 0);
        send(16'h0002, 0, 0, 0, 0, 0);
        send(16'h0003, 1, 0, 0, 0, 0);
        send(16'h0004, 1, 0, 0, 0, 1);
        @(negedge clk);
        num_valid    = 1'b1;
        num_data     = 16'h0005;
        clear_counts = 1'b1;
        #1;
        check("clear_blocks_ready", 64'(num_ready), 64'd0);
        @(negedge clk);
        check("clear_counters", 64'(cur_resp()), 64'({1'b1, 1'b0, 1'b0, 16'd0, 16'd0}));
        clear_counts = 1'b0;
        apply(16'h0005, 1, 0, 0, 0, 1);

        // Build error_count 5 while locked, then reset mid-cycle
        for (int k = 1; k <= 5; k++) begin
            send(16'(k * 256), 1, 1, 0, 16'(k), 16'(k));
            send(16'(k * 256 + 1), 1, 0, 0, 16'(k), 16'(k + 1));
        end
        idle();
        check("pre_reset_state", 64'(cur_resp()), 64'({1'b1, 1'b0, 1'b0, 16'd5, 16'd6}));
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_outputs", 64'(cur_resp()), 64'd0);
        check("async_reset_ready", 64'(num_ready), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        apply(16'h0700, 0, 0, 0, 0, 0);
        send(16'h0701, 0, 0, 0, 0, 0);
        send(16'h0702, 0, 0, 0, 0, 0);
        send(16'h0703, 1, 0, 0, 0, 0);
        idle();
        repeat (2) @(negedge clk);

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/number_checker.md
NUMBER_CHECKER -- requirements
Module: number_checker

Interface
REQ-001 SHALL have parameter LOCK_THRESHOLD, default 4: consecutive in-sequence samples needed to lock (legal range 2..15).
REQ-002 SHALL have parameter LOSS_THRESHOLD, default 3: consecutive mismatches while locked that drop lock (legal range 1..15).
REQ-003 SHALL have port clk, input, 1: clock; all state changes on the rising edge.
REQ-004 SHALL have port reset, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port num_valid, input, 1: producer presents a sample.
REQ-006 SHALL have port num_data, input, 16: sample value.
REQ-007 SHALL have port num_ready, output, 1: checker accepts a sample this cycle.
REQ-008 SHALL have port clear_counts, input, 1: synchronous clear of both statistics counters.
REQ-009 SHALL have port locked, output, 1: registered; high while in LOCKED.
REQ-010 SHALL have port mismatch, output, 1: registered one-cycle pulse per mismatch counted in LOCKED.
REQ-011 SHALL have port lock_lost, output, 1: registered one-cycle pulse on LOCKED->ACQUIRE.
REQ-012 SHALL have port error_count, output, 16: saturating count of mismatches in LOCKED.
REQ-013 SHALL have port match_count, output, 16: saturating count of in-sequence samples accepted in LOCKED.

Function
REQ-014 SHALL drive num_ready = !reset && !clear_counts (combinational); a sample is accepted only when num_valid && num_ready.
REQ-015 SHALL define expected value as last accepted sample + 1, modulo 2^16 (0xFFFF followed by 0x0000 is in-sequence).
REQ-016 SHALL implement states IDLE, ACQUIRE, LOCKED; cycles without an accepted sample change no state, run counter or expected value.
REQ-017 IDLE: accepted sample SHALL load expected, set match run = 1, go to ACQUIRE.
REQ-018 ACQUIRE, in-sequence: run++; when run reaches LOCK_THRESHOLD SHALL go to LOCKED and clear miss run.
REQ-019 ACQUIRE, out-of-sequence: SHALL resync expected to sample+1 and set run = 1; no mismatch pulse, no count.
REQ-020 LOCKED, in-sequence: match_count++, miss run cleared.
REQ-021 LOCKED, out-of-sequence: mismatch pulse, error_count++, expected resynced to sample+1, miss run++.
REQ-022 When miss run reaches LOSS_THRESHOLD SHALL pulse lock_lost, leave LOCKED, enter ACQUIRE with run = 1 (the offending sample seeds the run).
REQ-023 mismatch, lock_lost, locked and counter updates SHALL be visible the cycle after the accepting edge (latency 1).
REQ-024 Counters SHALL saturate at 0xFFFF and never wrap.
REQ-025 clear_counts SHALL zero both counters at the next edge, leave state, expected and runs unchanged, and block acceptance that cycle.

Reset
REQ-026 On reset assertion, at any time including mid-run, SHALL immediately force: state IDLE, locked 0, mismatch 0, lock_lost 0, error_count 0, match_count 0, runs 0, expected 0, num_ready 0.
REQ-027 First edge after reset release SHALL be able to accept a sample.

Structure
REQ-028 Shared package number_pkg SHALL hold: NUM_W = 16, state enum (IDLE, ACQUIRE, LOCKED), default LOCK_THRESHOLD/LOSS_THRESHOLD constants.
REQ-029 A sub-module sat_counter (width-parameterised, inc/clr inputs, clr priority) SHALL be instantiated twice for error_count and match_count.

Verification
REQ-030 After reset, valid every cycle with 0x1234,0x1235,0x1236,0x1237 -> locked rises the cycle after 0x1237 accepted; error_count 0, match_count 0.
REQ-031 Locked on ...0xFFFE,0xFFFF,0x0000 -> no mismatch, match_count +2 beyond the lock point.
REQ-032 Locked, then 0x0100,0x0050,0x0051 -> one mismatch pulse at 0x0050, error_count 1, still locked, miss run cleared by 0x0051.
REQ-033 Locked, then three unrelated values 0x0AAA,0x0555,0x0F0F -> three mismatch pulses, lock_lost pulse with the third, locked 0, error_count 3.
REQ-034 Drive from number_generator after common reset (0x4A46 then 0x0000,0x0001,...) -> one ACQUIRE resync, locked after 0x0003, error_count stays 0; clear_counts with num_valid high -> num_ready 0, sample not consumed, counters 0 next cycle.
REQ-035 Assert reset mid-run while locked with error_count 5 -> all outputs 0 immediately, relock needs LOCK_THRESHOLD fresh samples.
